// File: rtl/snake_move_sched_if.sv
// Heading type shared by the scheduler and its consumers, plus the control/status
// bundle between the player input stage, the scheduler and the board logic.
package snake_pkg;
    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } direction_t;
endpackage

interface snake_move_sched_if #(
    parameter int QDEPTH = 4
);
    import snake_pkg::*;

    logic                          en;
    logic                          turn_left;
    logic                          turn_right;
    direction_t                    dir;
    logic                          step;
    logic [$clog2(QDEPTH+1)-1:0]   q_level;
    logic                          overflow;

    modport master (
        output en, turn_left, turn_right,
        input  dir, step, q_level, overflow
    );

    modport slave (
        input  en, turn_left, turn_right,
        output dir, step, q_level, overflow
    );
endinterface

// File: rtl/snake_move_sched.sv
// Snake movement scheduler: internal game-step tick, queued relative turns
// resolved against the last queued heading, one turn released per step.
module snake_move_sched #(
    parameter int TICK_DIV = 6_500_000,
    parameter int QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    snake_move_sched_if.slave   bus
);
    import snake_pkg::*;

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(QDEPTH);
    localparam int LW = $clog2(QDEPTH+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV-1);
    localparam logic [LW-1:0] LVL_FULL = LW'(QDEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;
    logic          ovf_q, ovf_d;
    direction_t    dir_q, dir_d;
    direction_t    tail_q, tail_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    direction_t    mem_q [QDEPTH];

    logic          fire, pop, push_req, push_ok, full, wr_en;
    direction_t    entry;

    function automatic direction_t rot_ccw(direction_t d);
        logic [1:0] t;
        t = d;
        t = t - 2'd1;
        return direction_t'(t);
    endfunction

    function automatic direction_t rot_cw(direction_t d);
        logic [1:0] t;
        t = d;
        t = t + 2'd1;
        return direction_t'(t);
    endfunction

    always_comb begin
        cnt_d    = cnt_q;
        step_d   = 1'b0;
        ovf_d    = 1'b0;
        dir_d    = dir_q;
        tail_d   = tail_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        fire     = (cnt_q == CNT_MAX);
        full     = (level_q == LVL_FULL);
        push_req = bus.turn_left ^ bus.turn_right;
        entry    = bus.turn_left ? rot_ccw(tail_q) : rot_cw(tail_q);
        pop      = 1'b0;
        push_ok  = 1'b0;
        wr_en    = 1'b0;

        if (!bus.en) begin
            // Pause flushes the queue; the tail re-anchors to the live heading.
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
            tail_d   = dir_q;
        end else begin
            cnt_d  = fire ? '0 : cnt_q + CW'(1);
            step_d = fire;
            pop    = fire && (level_q != '0);
            if (pop) begin
                dir_d    = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_req) begin
                if (!full || pop) begin
                    push_ok  = 1'b1;
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    tail_d   = entry;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            step_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dir_q    <= UP;
            tail_q   <= UP;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            ovf_q    <= ovf_d;
            dir_q    <= dir_d;
            tail_q   <= tail_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by level_q and the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= entry;
    end

    assign bus.dir      = dir_q;
    assign bus.step     = step_q;
    assign bus.q_level  = level_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_snake_move_sched.sv
// Bench for snake_move_sched: directed scenarios then random traffic, all checked
// cycle by cycle against a queue-based reference model.
module tb_snake_move_sched;
    import snake_pkg::*;

    localparam int TD = 8;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snake_move_sched_if #(.QDEPTH(QD)) bus ();

    snake_move_sched #(.TICK_DIV(TD), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Heading encoding UP=0 RIGHT=1 DOWN=2 LEFT=3; rotation tables from the rules.
    int left_of  [4] = '{3, 0, 1, 2};
    int right_of [4] = '{1, 2, 3, 0};

    int m_cnt, m_dir, m_tail, m_step, m_ovf;
    int mq[$];

    int n_cmp = 0;
    int n_err = 0;
    int steps_seen, ovf_seen, prev_dir;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit l, input bit rt);
        bit fire, pop, push, full;
        int nd;
        if (r) begin
            m_cnt = 0; m_dir = 0; m_tail = 0; m_step = 0; m_ovf = 0;
            mq.delete();
        end else if (!e) begin
            m_cnt = 0; m_step = 0; m_ovf = 0;
            mq.delete();
            m_tail = m_dir;
        end else begin
            fire   = (m_cnt == TD-1);
            m_cnt  = fire ? 0 : m_cnt + 1;
            m_step = fire;
            pop    = fire && (mq.size() > 0);
            push   = l ^ rt;
            full   = (mq.size() == QD);
            m_ovf  = push && full && !pop;
            nd     = l ? left_of[m_tail] : right_of[m_tail];
            if (pop) m_dir = mq.pop_front();
            if (push && (!full || pop)) begin
                mq.push_back(nd);
                m_tail = nd;
            end
        end
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic tick(input bit r, input bit e, input bit l, input bit rt);
        rst = r; bus.en = e; bus.turn_left = l; bus.turn_right = rt;
        prev_dir = int'(bus.dir);
        model(r, e, l, rt);
        @(posedge clk);
        #1;
        check("dir",      int'(bus.dir),      m_dir);
        check("step",     int'(bus.step),     m_step);
        check("q_level",  int'(bus.q_level),  mq.size());
        check("overflow", int'(bus.overflow), m_ovf);
        if (bus.step) begin
            steps_seen++;
            check("no_reversal", int'(int'(bus.dir) == (prev_dir + 2) % 4), 0);
        end
        if (bus.overflow) ovf_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.turn_left = 1'b0; bus.turn_right = 1'b0;
        m_cnt = 0; m_dir = 0; m_tail = 0; m_step = 0; m_ovf = 0;
        steps_seen = 0; ovf_seen = 0; prev_dir = 0;
        #2;

        // Reset, then free-running steps with no turns
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_dir", int'(bus.dir), int'(UP));
        steps_seen = 0;
        run(32);
        check("steps_in_32", steps_seen, 4);
        check("dir_still_up", int'(bus.dir), int'(UP));

        // Single left pulse at cycle 2
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        run(1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        check("qlvl_after_left", int'(bus.q_level), 1);
        run(6);
        check("dir_left", int'(bus.dir), int'(LEFT));

        // Three lefts within one period
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        run(28);
        check("dir_after_3_lefts", int'(bus.dir), int'(UP));

        // Five rights before the first step: fills queue, one overflow
        ovf_seen = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("qlvl_full", int'(bus.q_level), QD);
        run(40);
        check("ovf_count", ovf_seen, 1);
        check("dir_after_4_rights", int'(bus.dir), int'(UP));

        // Both turns together; then right exactly on the step cycle
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        check("both_no_push", int'(bus.q_level), 0);
        run(5);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("no_bypass_dir", int'(bus.dir), int'(UP));
        run(8);
        check("right_next_step", int'(bus.dir), int'(RIGHT));

        // Pause flush, then reset mid-queue
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_qlvl", int'(bus.q_level), 0);
        check("flush_dir", int'(bus.dir), int'(RIGHT));
        run(10);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_dir", int'(bus.dir), int'(UP));
        check("rst_qlvl", int'(bus.q_level), 0);
        run(12);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
